// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 16-bit data-memory port among NCORES requesters,
// with 2-cycle load-return tracking. Define MEM_ARB_STORE_PRIO_EN to favour stores over loads.
module mem_port_arbiter #(
  parameter int NCORES = 4,
  parameter int CW     = $clog2(NCORES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NCORES-1:0]    req_valid_i,
  input  logic [NCORES-1:0]    req_we_i,
  input  logic [NCORES*16-1:0] req_addr_i,
  input  logic [NCORES*16-1:0] req_wdata_i,
  output logic [NCORES-1:0]    grant_o,
  output logic [NCORES-1:0]    rdata_valid_o,
  output logic [15:0]          rdata_o,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [15:0]          mem_addr_o,
  output logic [15:0]          mem_wdata_o,
  input  logic [15:0]          mem_rdata_i
);

  logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              pend1_v_q, pend1_v_d;
  logic [CW-1:0]     pend1_id_q, pend1_id_d;
  logic              pend2_v_q;
  logic [CW-1:0]     pend2_id_q;

  logic [NCORES-1:0] elig;
  logic [CW:0]       pick;
  logic              gnt_any;
  logic [CW-1:0]     gidx;

  // Returns {found, index} of the first set bit at or after ptr, wrapping.
  function automatic logic [CW:0] rr_pick(input logic [NCORES-1:0] vec,
                                          input logic [CW-1:0]     ptr);
    logic [CW:0] res;
    int          idx;
    res = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NCORES;
      if (vec[idx]) res = {1'b1, CW'(idx)};
    end
    return res;
  endfunction

  // A load is blocked only while its previous load sits in the first pipe stage.
  always_comb begin
    elig = '0;
    for (int k = 0; k < NCORES; k++) begin
      elig[k] = req_valid_i[k] &&
                (req_we_i[k] || !(pend1_v_q && (pend1_id_q == CW'(k))));
    end
  end

  always_comb begin
    pick = '0;
`ifdef MEM_ARB_STORE_PRIO_EN
    if (|(elig & req_we_i)) pick = rr_pick(elig & req_we_i, rr_ptr_q);
    else                    pick = rr_pick(elig & ~req_we_i, rr_ptr_q);
`else
    pick = rr_pick(elig, rr_ptr_q);
`endif
  end

  assign gnt_any = pick[CW] && !rst_i;
  assign gidx    = pick[CW-1:0];

  always_comb begin
    grant_o     = '0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    rr_ptr_d    = rr_ptr_q;
    pend1_v_d   = 1'b0;
    pend1_id_d  = pend1_id_q;
    if (gnt_any) begin
      grant_o[gidx] = 1'b1;
      mem_en_o      = 1'b1;
      mem_we_o      = req_we_i[gidx];
      mem_addr_o    = req_addr_i[gidx*16 +: 16];
      mem_wdata_o   = req_wdata_i[gidx*16 +: 16];
      rr_ptr_d      = (int'(gidx) == NCORES - 1) ? '0 : gidx + CW'(1);
      if (!req_we_i[gidx]) begin
        pend1_v_d  = 1'b1;
        pend1_id_d = gidx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      pend1_v_q  <= 1'b0;
      pend1_id_q <= '0;
      pend2_v_q  <= 1'b0;
      pend2_id_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      pend1_v_q  <= pend1_v_d;
      pend1_id_q <= pend1_id_d;
      pend2_v_q  <= pend1_v_q;
      pend2_id_q <= pend1_id_q;
    end
  end

  always_comb begin
    rdata_valid_o = '0;
    if (pend2_v_q) rdata_valid_o[pend2_id_q] = 1'b1;
  end

  assign rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a 2-cycle-latency memory model.
// Expectations follow MEM_ARB_STORE_PRIO_EN when it is defined.
module tb_mem_port_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_we;
  logic [N*16-1:0] req_addr, req_wdata;
  logic [N-1:0]  grant, rdata_valid;
  logic [15:0]   rdata, mem_addr, mem_wdata, mem_rdata;
  logic          mem_en, mem_we;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:255];
  logic [15:0] s1, s2;

  mem_port_arbiter #(.NCORES(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .grant_o(grant), .rdata_valid_o(rdata_valid), .rdata_o(rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: write at the edge, read data appears two cycles after the load edge.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    s1 <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 16'hxxxx;
    s2 <= s1;
  end
  assign mem_rdata = s2;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int k, input logic we, input logic [15:0] a, input logic [15:0] d);
    req_valid[k]         = 1'b1;
    req_we[k]            = we;
    req_addr[k*16 +: 16] = a;
    req_wdata[k*16 +: 16] = d;
  endtask

  task automatic clr_reqs();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic do_reset();
    clr_reqs();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clr_reqs();
    rst = 1'b1;
    set_req(1, 1'b0, 16'h0001, 16'h0);
    cyc();
    checks++;
    if (grant !== 4'b0000 || mem_en !== 1'b0) begin
      errors++; $display("FAIL reset_gate: grant=%b mem_en=%b, want 0000/0", grant, mem_en);
    end
    clr_reqs();
    cyc();
    checks++;
    if (rdata_valid !== 4'b0000 || mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      errors++; $display("FAIL reset_outs: rv=%b we=%b addr=%h wd=%h, want all 0", rdata_valid, mem_we, mem_addr, mem_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_load();
    do_reset();
    mem[8'h10] = 16'hBEEF;
    set_req(2, 1'b0, 16'h0010, 16'h0);
    #1;
    checks++;
    if (grant !== 4'b0100 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010) begin
      errors++; $display("FAIL single_grant: grant=%b en=%b we=%b addr=%h, want 0100/1/0/0010", grant, mem_en, mem_we, mem_addr);
    end
    cyc(); clr_reqs(); #1;
    checks++;
    if (rdata_valid !== 4'b0000) begin
      errors++; $display("FAIL single_t1: rdata_valid=%b, want 0000", rdata_valid);
    end
    cyc();
    checks++;
    if (rdata_valid !== 4'b0100 || rdata !== 16'hBEEF) begin
      errors++; $display("FAIL single_t2: rv=%b rdata=%h, want 0100/beef", rdata_valid, rdata);
    end
    cyc();
    checks++;
    if (rdata_valid !== 4'b0000) begin
      errors++; $display("FAIL single_t3: rdata_valid=%b, want 0000", rdata_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g, exp_rv;
    do_reset();
    for (int k = 0; k < N; k++) begin
      mem[8'h40 + k] = 16'hA000 + 16'(k);
      set_req(k, 1'b0, 16'h0040 + 16'(k), 16'h0);
    end
    #1;
    for (int i = 0; i < 10; i++) begin
      exp_g = 4'b0001 << (i % 4);
      exp_rv = (i >= 2) ? (4'b0001 << ((i - 2) % 4)) : 4'b0000;
      checks++;
      if (grant !== exp_g || rdata_valid !== exp_rv) begin
        errors++; $display("FAIL rr_cycle%0d: grant=%b rv=%b, want %b/%b", i, grant, rdata_valid, exp_g, exp_rv);
      end
      if (i >= 2) begin
        checks++;
        if (rdata !== 16'hA000 + 16'((i - 2) % 4)) begin
          errors++; $display("FAIL rr_data%0d: rdata=%h, want %h", i, rdata, 16'hA000 + 16'((i - 2) % 4));
        end
      end
      cyc();
    end
    clr_reqs();
  endtask

  task automatic test_back_to_back();
    logic [2:0] en_seen;
    logic [3:0] g_seen [3];
    do_reset();
    set_req(1, 1'b0, 16'h0050, 16'h0);
    #1;
    for (int i = 0; i < 3; i++) begin
      en_seen[i] = mem_en;
      g_seen[i]  = grant;
      cyc();
    end
    clr_reqs();
    checks++;
    if (en_seen !== 3'b101) begin
      errors++; $display("FAIL b2b_mem_en: pattern(t2..t0)=%b, want 101", en_seen);
    end
    checks++;
    if (g_seen[0] !== 4'b0010 || g_seen[1] !== 4'b0000 || g_seen[2] !== 4'b0010) begin
      errors++; $display("FAIL b2b_grant: %b %b %b, want 0010 0000 0010", g_seen[0], g_seen[1], g_seen[2]);
    end
  endtask

  task automatic test_store_vs_load();
    do_reset();
    set_req(0, 1'b0, 16'h0060, 16'h0);
    set_req(3, 1'b1, 16'h0020, 16'h1234);
    #1;
`ifdef MEM_ARB_STORE_PRIO_EN
    checks++;
    if (grant !== 4'b1000 || mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 16'h1234) begin
      errors++; $display("FAIL prio_first: grant=%b we=%b addr=%h wd=%h, want 1000/1/0020/1234", grant, mem_we, mem_addr, mem_wdata);
    end
    cyc();
    req_valid[3] = 1'b0; #1;
    checks++;
    if (grant !== 4'b0001 || mem_we !== 1'b0) begin
      errors++; $display("FAIL prio_second: grant=%b we=%b, want 0001/0", grant, mem_we);
    end
`else
    checks++;
    if (grant !== 4'b0001 || mem_we !== 1'b0) begin
      errors++; $display("FAIL rr_mix_first: grant=%b we=%b, want 0001/0", grant, mem_we);
    end
    cyc();
    req_valid[0] = 1'b0; #1;
    checks++;
    if (grant !== 4'b1000 || mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 16'h1234) begin
      errors++; $display("FAIL rr_mix_second: grant=%b we=%b addr=%h wd=%h, want 1000/1/0020/1234", grant, mem_we, mem_addr, mem_wdata);
    end
`endif
    cyc();
    clr_reqs();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    set_req(0, 1'b0, 16'h0070, 16'h0);
    #1;
    checks++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL rst_inflight_grant: grant=%b, want 0001", grant);
    end
    cyc();
    clr_reqs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (rdata_valid !== 4'b0000) begin
      errors++; $display("FAIL rst_inflight_drop: rdata_valid=%b, want 0000", rdata_valid);
    end
    set_req(0, 1'b0, 16'h0071, 16'h0);
    set_req(1, 1'b0, 16'h0072, 16'h0);
    #1;
    checks++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL rst_ptr: grant=%b, want 0001 (rr_ptr back at 0)", grant);
    end
    cyc();
    clr_reqs();
    cyc(); cyc();
  endtask

  task automatic test_load_then_store();
    do_reset();
    mem[8'h30] = 16'h0005;
    set_req(0, 1'b0, 16'h0030, 16'h0);
    #1;
    cyc();
    clr_reqs();
    set_req(1, 1'b1, 16'h0030, 16'h0009);
    #1;
    checks++;
    if (grant !== 4'b0010 || mem_we !== 1'b1) begin
      errors++; $display("FAIL ls_store_grant: grant=%b we=%b, want 0010/1", grant, mem_we);
    end
    cyc();
    clr_reqs();
    checks++;
    if (rdata_valid !== 4'b0001 || rdata !== 16'h0005) begin
      errors++; $display("FAIL ls_old_data: rv=%b rdata=%h, want 0001/0005", rdata_valid, rdata);
    end
    set_req(2, 1'b0, 16'h0030, 16'h0);
    #1;
    cyc();
    clr_reqs();
    cyc();
    checks++;
    if (rdata_valid !== 4'b0100 || rdata !== 16'h0009) begin
      errors++; $display("FAIL ls_new_data: rv=%b rdata=%h, want 0100/0009", rdata_valid, rdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    clr_reqs();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    test_reset();
    test_single_load();
    test_round_robin();
    test_back_to_back();
    test_store_vs_load();
    test_reset_inflight();
    test_load_then_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
